// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and helpers for the memory request arbiter and its round-robin picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    WAIT_WR
  } arb_state_t;

  localparam int unsigned DEF_ADDR_WIDTH = 32;
  localparam int unsigned DEF_DATA_WIDTH = 32;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit scanning upward from rr_ptr, wrapping.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]             req,
  input  logic [idx_width(NUM_REQ)-1:0]  rr_ptr,
  output logic [idx_width(NUM_REQ)-1:0]  winner,
  output logic                           any_valid
);

  localparam int unsigned IW = idx_width(NUM_REQ);

  int unsigned idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = (32'(rr_ptr) + i) % NUM_REQ;
      if (!any_valid && req[idx]) begin
        any_valid = 1'b1;
        winner    = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter granting one full single-beat transaction at a time onto a shared bridge port.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                s_req_valid,
  input  logic [NUM_REQ-1:0]                s_req_is_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]     s_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]     s_req_wdata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]   s_req_wstrb,
  output logic [NUM_REQ-1:0]                s_req_ready,
  output logic [DATA_WIDTH-1:0]             s_resp_rdata,
  output logic [NUM_REQ-1:0]                s_resp_valid,
  input  logic [NUM_REQ-1:0]                s_resp_ready,
  output logic [NUM_REQ-1:0]                s_wr_done,
  output logic                              m_req_valid,
  output logic                              m_req_is_write,
  output logic [ADDR_WIDTH-1:0]             m_req_addr,
  output logic [DATA_WIDTH-1:0]             m_req_wdata,
  output logic [DATA_WIDTH/8-1:0]           m_req_wstrb,
  input  logic                              m_req_ready,
  input  logic [DATA_WIDTH-1:0]             m_resp_rdata,
  input  logic                              m_resp_valid,
  output logic                              m_resp_ready,
  output logic [idx_width(NUM_REQ)-1:0]     grant_id,
  output logic                              busy
);

  localparam int unsigned IW = idx_width(NUM_REQ);
  localparam int unsigned SW = DATA_WIDTH / 8;

  arb_state_t    state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] winner;
  logic          any_valid;

  rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req       (s_req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      grant_id       <= '0;
      m_req_is_write <= 1'b0;
      m_req_addr     <= '0;
      m_req_wdata    <= '0;
      m_req_wstrb    <= '0;
      s_wr_done      <= '0;
    end else begin
      s_wr_done <= '0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            m_req_is_write <= s_req_is_write[winner];
            m_req_addr     <= s_req_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
            m_req_wdata    <= s_req_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
            m_req_wstrb    <= s_req_wstrb[winner*SW +: SW];
            grant_id       <= winner;
            rr_ptr         <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + IW'(1);
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          if (m_req_ready) state <= m_req_is_write ? WAIT_WR : WAIT_RD;
        end
        WAIT_RD: begin
          if (m_resp_valid && m_resp_ready) state <= IDLE;
        end
        WAIT_WR: begin
          // Bridge signals write completion only by becoming idle again.
          if (m_req_ready) begin
            s_wr_done <= NUM_REQ'(1) << grant_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    s_req_ready  = '0;
    s_resp_valid = '0;
    s_resp_rdata = '0;
    m_resp_ready = 1'b0;
    m_req_valid  = (state == ISSUE);
    busy         = (state != IDLE);
    if (rst_n && state == IDLE && any_valid) s_req_ready[winner] = 1'b1;
    if (state == WAIT_RD) begin
      m_resp_ready           = s_resp_ready[grant_id];
      s_resp_valid[grant_id] = m_resp_valid;
      s_resp_rdata           = m_resp_rdata;
    end
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Round-robin arbiter that shares one single-beat memory bridge request port between NUM_REQ requesters (GPU cores, cache refill/writeback).
- Each requester gets a full transaction, from request through read response or write completion, before the next grant. This matches the bridge's one-outstanding-op limit.
- Sits between requester-side memory interfaces and the bridge's req/resp port.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width (multiple of 8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_req_valid  in  NUM_REQ  per-requester request valid.
- s_req_is_write  in  NUM_REQ  per-requester write flag.
- s_req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- s_req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- s_req_wstrb  in  NUM_REQ*DATA_WIDTH/8  packed byte strobes.
- s_req_ready  out  NUM_REQ  one-hot accept strobe.
- s_resp_rdata  out  DATA_WIDTH  read data, broadcast to all requesters.
- s_resp_valid  out  NUM_REQ  one-hot read-response valid.
- s_resp_ready  in  NUM_REQ  per-requester response ready.
- s_wr_done  out  NUM_REQ  one-hot single-cycle write-complete pulse.
- m_req_valid  out  1  request to bridge.
- m_req_is_write  out  1  write flag to bridge.
- m_req_addr  out  ADDR_WIDTH  address to bridge.
- m_req_wdata  out  DATA_WIDTH  write data to bridge.
- m_req_wstrb  out  DATA_WIDTH/8  byte strobes to bridge.
- m_req_ready  in  1  bridge idle/accept.
- m_resp_rdata  in  DATA_WIDTH  read data from bridge.
- m_resp_valid  in  1  read response valid from bridge.
- m_resp_ready  out  1  response ready to bridge.
- grant_id  out  $clog2(NUM_REQ)  current/last granted requester.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, rr_ptr=0, grant_id=0.
  - All outputs 0; latched request registers 0.
- IDLE:
  - Pick the first valid requester scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - s_req_ready[g] is combinational: high in the same cycle as s_req_valid[g] when g is the winner. All other ready bits stay 0.
  - On that cycle: latch is_write/addr/wdata/wstrb of g, set grant_id=g, set rr_ptr=(g+1) mod NUM_REQ, go to ISSUE.
  - If no request is valid, stay in IDLE with rr_ptr unchanged.
- ISSUE:
  - m_req_valid=1 and m_req_* driven from the latched registers, held stable until accepted.
  - Accept is m_req_valid & m_req_ready. On accept go to WAIT_RD if the request is a read, else WAIT_WR.
- WAIT_RD:
  - m_resp_ready = s_resp_ready[grant_id].
  - s_resp_valid[grant_id] = m_resp_valid; s_resp_rdata = m_resp_rdata (combinational pass-through).
  - On m_resp_valid & m_resp_ready go to IDLE.
  - A requester holding resp_ready low stalls the arbiter indefinitely.
- WAIT_WR:
  - The bridge returns no write response; completion is m_req_ready returning high.
  - On m_req_ready=1: pulse s_wr_done[grant_id] for 1 cycle (registered), go to IDLE.
  - m_req_ready must be sampled only in WAIT_WR, never in the accept cycle.
- Latency:
  - Grant to m_req_valid is 1 cycle.
  - Back-to-back: the next grant can occur in the cycle after returning to IDLE, so there are at least 2 cycles between consecutive m_req_valid assertions.
- Simultaneous requests are resolved purely by rr_ptr. A requester that drops valid before ready is simply skipped.
- s_resp_valid, s_wr_done and s_req_ready are each at most one-hot at any time.
- m_resp_valid arriving outside WAIT_RD is ignored (m_resp_ready=0).
- Reset mid-transaction abandons the transaction; no done/resp is emitted. The bridge is reset on the same rst_n.

Decomposition:
- Package mem_arb_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT_RD, WAIT_WR};
  - a function for the index width;
  - defaults for ADDR_WIDTH/DATA_WIDTH.
- One natural sub-module: rr_picker.
  - Combinational; inputs req vector and rr_ptr; outputs winner index and any_valid.
  - Reusable by other shared-port schedulers.

Test Plan:
- Single read: req1 read addr 0x100, bridge returns 0xDEADBEEF after 3 cycles -> s_req_ready[1] in cycle 0, m_req_valid in cycle 1, s_resp_valid[1]=1 with rdata 0xDEADBEEF, all other resp bits 0.
- Single write: req2 write addr 0x200, wdata 0x12345678, wstrb 0xF -> m_req_* match the request exactly; s_wr_done[2] pulses once after m_req_ready returns high; no s_resp_valid.
- Fairness: all 4 requesters hold valid continuously from reset -> grant order 0,1,2,3,0,1; each requester's ready asserts exactly once per round.
- Response backpressure: req0 read with s_resp_ready[0]=0 for 5 cycles -> m_resp_ready stays 0, m_resp_valid is held, and no new grant is issued until ready rises.
- Wrap/skip: rr_ptr=3, valids={0,2} -> grants 0 then 2; rr_ptr ends at 3.
- Reset mid-read: assert rst_n low in WAIT_RD -> busy=0, all outputs 0, rr_ptr=0 immediately; the first post-reset request from requester 0 is serviced normally.
